// File: rtl/updi_pkg.sv
// Shared UPDI types and constants used by the instruction arbiter and related blocks.
package updi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2,
    ABORT  = 2'd3
  } updi_arb_state_t;

  localparam logic [7:0] UPDI_SYNCH         = 8'h55;
  localparam int         UPDI_MAX_DATA_SIZE = 16;

endpackage

// File: rtl/updi_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after the pointer, wrapping.
module updi_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  localparam int SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] w_sum;
  logic [IDX_W-1:0] w_c;

  // Walk from the farthest offset down so the nearest candidate overwrites last.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_sum = '0;
    w_c   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, i_ptr} + SUM_W'(k);
      if (w_sum >= SUM_W'(NUM_REQ)) w_sum = w_sum - SUM_W'(NUM_REQ);
      w_c = w_sum[IDX_W-1:0];
      if (i_req[w_c]) begin
        o_gnt      = '0;
        o_gnt[w_c] = 1'b1;
        o_idx      = w_c;
        o_any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/updi_instruction_arbiter.sv
// Round-robin arbiter sharing one UPDI instruction queue handler between several requesters,
// with ACK-wait watchdog that aborts and resets a hung handler.
module updi_instruction_arbiter
  import updi_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int MAX_DATA_SIZE  = UPDI_MAX_DATA_SIZE,
  parameter int DATA_ADDR_BITS = $clog2(MAX_DATA_SIZE),
  parameter int ACK_TIMEOUT    = 4096
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    i_req,
  input  logic [NUM_REQ*8-1:0]                  i_req_opcode,
  input  logic [NUM_REQ*MAX_DATA_SIZE*8-1:0]    i_req_data,
  input  logic [NUM_REQ*(DATA_ADDR_BITS+1)-1:0] i_req_data_len,
  input  logic [NUM_REQ*MAX_DATA_SIZE-1:0]      i_req_wait_ack_after,
  output logic [NUM_REQ-1:0]                    o_gnt,
  output logic [NUM_REQ-1:0]                    o_req_done,
  output logic [NUM_REQ-1:0]                    o_req_error,
  output logic                                  o_hdl_start,
  output logic                                  o_hdl_rst,
  output logic [7:0]                            o_hdl_opcode,
  output logic [MAX_DATA_SIZE*8-1:0]            o_hdl_data,
  output logic [DATA_ADDR_BITS:0]               o_hdl_data_len,
  output logic [MAX_DATA_SIZE-1:0]              o_hdl_wait_ack_after,
  input  logic                                  i_hdl_ready,
  input  logic                                  i_hdl_done,
  input  logic                                  i_hdl_waiting_for_ack
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int LEN_W = DATA_ADDR_BITS + 1;
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_DATA_SIZE);

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > MAX_LEN) ? MAX_LEN : len;
  endfunction

  updi_arb_state_t r_state, w_state_nxt;

  logic [NUM_REQ-1:0]         r_gnt;
  logic [IDX_W-1:0]           r_gnt_idx;
  logic [IDX_W-1:0]           r_ptr;
  logic                       r_seen_busy;
  logic [CNT_W-1:0]           r_to_cnt;
  logic                       r_abort_q;
  logic [7:0]                 r_hdl_opcode;
  logic [MAX_DATA_SIZE*8-1:0] r_hdl_data;
  logic [LEN_W-1:0]           r_hdl_len;
  logic [MAX_DATA_SIZE-1:0]   r_hdl_mask;

  logic [NUM_REQ-1:0] w_pick_gnt;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_pick_any;
  logic               w_grant;
  logic               w_timeout;
  logic               w_finish;
  logic [IDX_W-1:0]   w_ptr_nxt;

  updi_rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  assign w_grant   = (r_state == IDLE) && i_hdl_ready && w_pick_any;
  assign w_timeout = (r_state == BUSY) && i_hdl_waiting_for_ack &&
                     (r_to_cnt == CNT_W'(ACK_TIMEOUT - 1));
  // The handler may finish without a done pulse: ready returning after it was seen busy.
  assign w_finish  = (r_state == BUSY) && !w_timeout &&
                     (i_hdl_done || (r_seen_busy && i_hdl_ready));
  assign w_ptr_nxt = (r_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_gnt_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_hdl_start = 1'b0;
    o_req_done  = '0;
    o_req_error = '0;
    case (r_state)
      IDLE:   if (w_grant) w_state_nxt = LAUNCH;
      LAUNCH: begin
        o_hdl_start = 1'b1;
        w_state_nxt = BUSY;
      end
      BUSY: begin
        if (w_timeout)     w_state_nxt = ABORT;
        else if (w_finish) w_state_nxt = IDLE;
        if (w_finish && !rst) o_req_done = r_gnt;
      end
      ABORT: begin
        w_state_nxt = IDLE;
        if (!rst) o_req_error = r_gnt;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt        <= '0;
      r_gnt_idx    <= '0;
      r_ptr        <= '0;
      r_seen_busy  <= 1'b0;
      r_to_cnt     <= '0;
      r_abort_q    <= 1'b0;
      r_hdl_opcode <= '0;
      r_hdl_data   <= '0;
      r_hdl_len    <= '0;
      r_hdl_mask   <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_grant) begin
          r_gnt        <= w_pick_gnt;
          r_gnt_idx    <= w_pick_idx;
          r_seen_busy  <= 1'b0;
          r_to_cnt     <= '0;
          r_hdl_opcode <= i_req_opcode[w_pick_idx*8 +: 8];
          r_hdl_data   <= i_req_data[w_pick_idx*MAX_DATA_SIZE*8 +: MAX_DATA_SIZE*8];
          r_hdl_len    <= clamp_len(i_req_data_len[w_pick_idx*LEN_W +: LEN_W]);
          r_hdl_mask   <= i_req_wait_ack_after[w_pick_idx*MAX_DATA_SIZE +: MAX_DATA_SIZE];
        end
        BUSY: begin
          if (!i_hdl_ready) r_seen_busy <= 1'b1;
          r_to_cnt <= i_hdl_waiting_for_ack ? r_to_cnt + 1'b1 : '0;
          if (w_timeout) begin
            r_abort_q <= 1'b1;
          end else if (w_finish) begin
            r_gnt <= '0;
            r_ptr <= w_ptr_nxt;
          end
        end
        ABORT: begin
          r_abort_q <= 1'b0;
          r_gnt     <= '0;
          r_ptr     <= w_ptr_nxt;
        end
        default: ;
      endcase
    end
  end

  assign o_gnt                = r_gnt;
  assign o_hdl_rst            = rst | r_abort_q;
  assign o_hdl_opcode         = r_hdl_opcode;
  assign o_hdl_data           = r_hdl_data;
  assign o_hdl_data_len       = r_hdl_len;
  assign o_hdl_wait_ack_after = r_hdl_mask;

endmodule

// File: tb/tb_updi_instruction_arbiter.sv
// Bench for updi_instruction_arbiter: directed scenarios with literal expectations plus randomized
// traffic checked every cycle against a transaction-level reference model and a scripted handler.
module tb_updi_instruction_arbiter;

  localparam int N   = 4;
  localparam int MAX = 16;
  localparam int DAB = 4;
  localparam int LW  = DAB + 1;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]       req  = '0;
  logic [N*8-1:0]     opc  = '0;
  logic [N*MAX*8-1:0] data = '0;
  logic [N*LW-1:0]    len  = '0;
  logic [N*MAX-1:0]   mask = '0;
  logic ready = 1'b0, done = 1'b0, waitack = 1'b0;

  logic [N-1:0]     gnt, rdone, rerr;
  logic             hstart, hrst;
  logic [7:0]       hop;
  logic [MAX*8-1:0] hdata;
  logic [LW-1:0]    hlen;
  logic [MAX-1:0]   hmask;

  updi_instruction_arbiter #(
    .NUM_REQ(N), .MAX_DATA_SIZE(MAX), .DATA_ADDR_BITS(DAB), .ACK_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(req), .i_req_opcode(opc), .i_req_data(data), .i_req_data_len(len),
    .i_req_wait_ack_after(mask),
    .o_gnt(gnt), .o_req_done(rdone), .o_req_error(rerr),
    .o_hdl_start(hstart), .o_hdl_rst(hrst),
    .o_hdl_opcode(hop), .o_hdl_data(hdata), .o_hdl_data_len(hlen),
    .o_hdl_wait_ack_after(hmask),
    .i_hdl_ready(ready), .i_hdl_done(done), .i_hdl_waiting_for_ack(waitack)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Values the next cycle will apply to the DUT
  logic               pend_rst  = 1'b1;
  logic [N-1:0]       pend_req  = '0;
  logic [N*8-1:0]     pend_opc  = '0;
  logic [N*MAX*8-1:0] pend_data = '0;
  logic [N*LW-1:0]    pend_len  = '0;
  logic [N*MAX-1:0]   pend_mask = '0;

  // Reference model: owner of the handler, where it is in its transaction, rotation pointer, snapshot
  int m_own = -1, m_ptr = 0, m_cnt = 0;
  bit m_launch = 0, m_abort = 0, m_seen = 0;
  logic [7:0] m_op = '0; logic [MAX*8-1:0] m_data = '0; logic [LW-1:0] m_len = '0; logic [MAX-1:0] m_mask = '0;
  int n_own = -1, n_ptr = 0, n_cnt = 0;
  bit n_launch = 0, n_abort = 0, n_seen = 0;
  logic [7:0] n_op = '0; logic [MAX*8-1:0] n_data = '0; logic [LW-1:0] n_len = '0; logic [MAX-1:0] n_mask = '0;

  // Scripted handler: each entry is {ready, done, waiting_for_ack} for one cycle
  logic [2:0] h_q[$];
  bit h_hang = 0, p_start = 0, p_hrst = 1;
  int h_force = -1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic load_script();
    int mode, b, w;
    mode = (h_force >= 0) ? h_force : int'($urandom_range(0, 9));
    if (mode <= 3) begin
      b = $urandom_range(1, 4);
      repeat (b) h_q.push_back({2'b00, ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0});
      h_q.push_back(3'b010);
    end else if (mode <= 7) begin
      b = $urandom_range(1, 3);
      w = $urandom_range(0, 20);
      repeat (b) h_q.push_back(3'b000);
      repeat (w) h_q.push_back(3'b001);
    end else if (mode == 8 || mode == 11) begin
      h_hang = 1;
    end else if (mode == 9) begin
      h_q.push_back(3'b110);
    end else if (mode == 10) begin
      h_q.push_back(3'b000); h_q.push_back(3'b000); h_q.push_back(3'b010);
    end else begin
      h_q.push_back(3'b000); h_q.push_back(3'b000);
      repeat (5) h_q.push_back(3'b001);
    end
  endtask

  task automatic cycle();
    logic [N-1:0] eg, ed, ee;
    bit es, eh, run, tmo, fin;
    int pick;
    logic [LW-1:0] l;
    @(posedge clk);
    m_own = n_own; m_ptr = n_ptr; m_cnt = n_cnt; m_launch = n_launch; m_abort = n_abort; m_seen = n_seen;
    m_op = n_op; m_data = n_data; m_len = n_len; m_mask = n_mask;
    #1;
    if (p_hrst) begin
      h_q.delete(); h_hang = 0;
      {ready, done, waitack} = 3'b000;
    end else begin
      if (p_start) load_script();
      if (h_q.size() > 0) {ready, done, waitack} = h_q.pop_front();
      else if (h_hang) {ready, done, waitack} = 3'b001;
      else begin
        ready = (m_own < 0 && h_force < 0) ? ($urandom_range(0, 7) != 0) : 1'b1;
        done = 1'b0; waitack = 1'b0;
      end
    end
    rst = pend_rst; req = pend_req; opc = pend_opc; data = pend_data; len = pend_len; mask = pend_mask;
    #1;
    eg  = (m_own >= 0) ? N'(1) << m_own : '0;
    run = (m_own >= 0) && !m_launch && !m_abort;
    tmo = run && waitack && (m_cnt == TMO - 1);
    fin = run && !tmo && (done || (m_seen && ready));
    ed  = (fin && !rst) ? eg : '0;
    ee  = (m_abort && !rst) ? eg : '0;
    es  = m_launch;
    eh  = rst || m_abort;
    chk("gnt", gnt, eg);
    chk("req_done", rdone, ed);
    chk("req_error", rerr, ee);
    chk("hdl_start", hstart, es);
    chk("hdl_rst", hrst, eh);
    chk("hdl_opcode", hop, m_op);
    chk("hdl_data", hdata, m_data);
    chk("hdl_data_len", hlen, m_len);
    chk("hdl_wait_ack_after", hmask, m_mask);
    p_start = es; p_hrst = eh;
    n_own = m_own; n_ptr = m_ptr; n_cnt = m_cnt; n_launch = m_launch; n_abort = m_abort; n_seen = m_seen;
    n_op = m_op; n_data = m_data; n_len = m_len; n_mask = m_mask;
    if (rst) begin
      n_own = -1; n_ptr = 0; n_cnt = 0; n_launch = 0; n_abort = 0; n_seen = 0;
      n_op = '0; n_data = '0; n_len = '0; n_mask = '0;
    end else if (m_own < 0) begin
      if (ready && req != '0) begin
        pick = -1;
        for (int k = 0; k < N; k++) if (pick < 0 && req[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
        n_own = pick; n_launch = 1; n_seen = 0; n_cnt = 0;
        n_op = opc[pick*8 +: 8];
        n_data = data[pick*MAX*8 +: MAX*8];
        l = len[pick*LW +: LW];
        n_len = (l > LW'(MAX)) ? LW'(MAX) : l;
        n_mask = mask[pick*MAX +: MAX];
      end
    end else if (m_launch) begin
      n_launch = 0;
    end else if (m_abort) begin
      n_abort = 0; n_ptr = (m_own + 1) % N; n_own = -1;
    end else if (tmo) begin
      n_abort = 1;
    end else if (fin) begin
      n_ptr = (m_own + 1) % N; n_own = -1;
    end else begin
      if (!ready) n_seen = 1;
      n_cnt = waitack ? m_cnt + 1 : 0;
    end
  endtask

  initial begin
    int g_at, s_at, d_at, dcnt, cnt, wcnt, a_at, gap;
    logic [7:0] s_op;
    logic [N-1:0] dval, prevg, errv, g2;
    int ord[5];
    int exp_ord[5] = '{0, 1, 2, 3, 0};

    pend_rst = 1; repeat (3) cycle();
    pend_rst = 0; repeat (2) cycle();
    chk("reset_gnt_idle", gnt, 4'b0000);
    chk("reset_opcode", hop, 8'h00);

    // Single requester, opcode C4, zero-length, done pulse from handler
    h_force = 10; pend_opc[7:0] = 8'hC4; pend_len[LW-1:0] = '0; pend_req = 4'b0001;
    cycle();
    g_at = -1; s_at = -1; d_at = -1; dcnt = 0; dval = '0; s_op = '0;
    for (int n = 1; n <= 30; n++) begin
      cycle();
      if (gnt != '0 && g_at < 0) begin
        g_at = n; pend_req = '0; pend_data[31:0] = $urandom(); pend_opc[7:0] = 8'h3A;
      end
      if (hstart && s_at < 0) begin s_at = n; s_op = hop; end
      if (rdone != '0) begin dcnt++; if (d_at < 0) begin d_at = n; dval = rdone; end end
    end
    chk("t1_gnt_latency", g_at, 1);
    chk("t1_start_latency", s_at, 1);
    chk("t1_start_opcode", s_op, 8'hC4);
    chk("t1_done_latency", d_at, 4);
    chk("t1_done_value", dval, 4'b0001);
    chk("t1_done_count", dcnt, 1);

    // All four requesting continuously: rotation from pointer 0 after reset
    pend_rst = 1; cycle(); pend_rst = 0;
    pend_req = 4'b1111; h_force = 10; prevg = '0; cnt = 0;
    for (int i = 0; i < 5; i++) ord[i] = -1;
    for (int n = 0; n < 100 && cnt < 5; n++) begin
      cycle();
      if (gnt != '0 && prevg == '0) begin ord[cnt] = oh_idx(gnt); cnt++; end
      prevg = gnt;
    end
    for (int i = 0; i < 5; i++) chk("t2_grant_order", ord[i], exp_ord[i]);
    pend_req = '0; repeat (12) cycle();

    // Hung handler waiting for ACK forever: watchdog abort, then next requester
    pend_rst = 1; cycle(); pend_rst = 0;
    pend_req = 4'b0001; h_force = 11;
    wcnt = 0; a_at = -1; gap = -1; errv = '0; g2 = '0; prevg = '0;
    for (int n = 1; n <= 80; n++) begin
      cycle();
      if (prevg == '0 && gnt != '0 && a_at < 0) pend_req = 4'b0010;
      prevg = gnt;
      if (a_at < 0) begin
        if (hrst) begin a_at = n; errv = rerr; h_force = 10; end
        else if (waitack) wcnt++;
      end else if (gap < 0 && gnt != '0) begin
        gap = n - a_at; g2 = gnt; pend_req = '0;
      end
    end
    chk("t4_wait_cycles", wcnt, TMO);
    chk("t4_error_value", errv, 4'b0001);
    chk("t4_regrant_gap", gap, 3);
    chk("t4_regrant_gnt", g2, 4'b0010);
    repeat (10) cycle();

    // Two-byte instruction ending on the ACK path: ready returns without a done pulse
    pend_rst = 1; cycle(); pend_rst = 0; cycle(); cycle();
    pend_req = 4'b0100; pend_len[2*LW +: LW] = LW'(2); pend_mask[2*MAX +: MAX] = 16'h0002; h_force = 12;
    cycle();
    d_at = -1; dcnt = 0; dval = '0;
    for (int n = 1; n <= 30; n++) begin
      cycle();
      if (gnt != '0) pend_req = '0;
      if (rdone != '0) begin dcnt++; if (d_at < 0) begin d_at = n; dval = rdone; end end
    end
    chk("t3_done_latency", d_at, 9);
    chk("t3_done_value", dval, 4'b0100);
    chk("t3_done_count", dcnt, 1);

    // Randomized traffic, occasional resets, model-checked every cycle
    h_force = -1;
    for (int c = 0; c < 3000; c++) begin
      pend_rst = ($urandom_range(0, 249) == 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) pend_req[i] = ~pend_req[i];
        if ($urandom_range(0, 7) == 0) begin
          pend_opc[i*8 +: 8] = 8'($urandom());
          for (int w = 0; w < 4; w++) pend_data[i*MAX*8 + w*32 +: 32] = $urandom();
          pend_len[i*LW +: LW] = LW'($urandom_range(0, 31));
          pend_mask[i*MAX +: MAX] = 16'($urandom());
        end
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
